// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the snake CPU accumulator ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_ROW  = 4'd3;
    localparam logic [3:0] OP_COL  = 4'd4;
    localparam logic [3:0] OP_INCL = 4'd5;
    localparam logic [3:0] OP_F    = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps per multiply.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    input  logic               i_step,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;

    // The product is exposed as the post-step value so the final step can be written back on the same edge.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product  = w_acc_next;
    assign o_last     = (r_cnt == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
        end else if (i_step && r_cnt != '0) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Accumulator ALU with A/B registers, status flags, tri-state A bus and
// multi-cycle shift/multiply ops handshaked to the control FSM via busy/done.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_ain,
    input  logic             c_bin,
    input  logic             c_alu,
    input  logic             c_aout,
    output logic [WIDTH-1:0] a_out,
    output logic             flag,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int HALF = WIDTH / 2;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sh;
    logic [SHW-1:0]     r_cnt;
    logic               r_shl;
    logic               r_flag;
    logic               r_zero;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;

    logic [SHW-1:0]     w_amt;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_wr_a;
    logic               w_wr_c;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_mul_start;
    logic               w_mul_step;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_last;

    assign w_amt       = r_b[SHW-1:0];
    assign w_is_shift  = (opcode == OP_SHL) || (opcode == OP_SHR);
    assign w_sh_next   = r_shl ? (r_sh << 1) : (r_sh >> 1);
    assign w_mul_start = (r_state == ST_IDLE) && c_alu && (opcode == OP_MUL);
    assign w_mul_step  = (r_state == ST_MUL);

    assign a_out = c_aout ? r_a : 'z;
    assign flag  = r_flag;
    assign zero  = r_zero;
    assign carry = r_carry;
    assign busy  = r_busy;
    assign done  = r_done;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_res  = r_a;
        w_cout = r_carry;
        w_wr_a = 1'b1;
        w_wr_c = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                {w_cout, w_res} = {1'b0, r_a} + {1'b0, r_b};
                w_wr_c = 1'b1;
            end
            OP_SUB: begin
                {w_cout, w_res} = {1'b0, r_a} - {1'b0, r_b};
                w_wr_c = 1'b1;
            end
            OP_ROW:  w_res = {{HALF{1'b0}}, r_b[WIDTH-1:HALF]};
            OP_COL:  w_res = {{HALF{1'b0}}, r_b[HALF-1:0]};
            OP_INCL: w_res = r_a | ({{(WIDTH-1){1'b0}}, 1'b1} << w_amt);
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_SHL, OP_SHR: w_res = r_a;
            default: w_wr_a = 1'b0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_mcand   (r_a),
        .i_mplier  (r_b),
        .i_step    (w_mul_step),
        .o_product (w_prod),
        .o_last    (w_mul_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_shl   <= 1'b0;
            r_flag  <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (c_ain) r_a <= a_in;
                    if (c_bin) r_b <= b_in;
                    // Op result is assigned after the load so it wins A on a shared edge.
                    if (c_alu) begin
                        if (w_is_shift && w_amt != '0) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                            r_sh    <= r_a;
                            r_cnt   <= w_amt;
                            r_shl   <= (opcode == OP_SHL);
                        end else if (opcode == OP_MUL) begin
                            r_state <= ST_MUL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            if (w_wr_a) begin
                                r_a    <= w_res;
                                r_zero <= (w_res == '0);
                            end
                            if (w_wr_c) r_carry <= w_cout;
                            if (opcode == OP_F) r_flag <= (r_a == r_b);
                        end
                    end
                end
                ST_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_a     <= w_sh_next;
                        r_zero  <= (w_sh_next == '0);
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) begin
                        r_a     <= w_prod[WIDTH-1:0];
                        r_zero  <= (w_prod[WIDTH-1:0] == '0);
                        r_carry <= |w_prod[2*WIDTH-1:WIDTH];
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: an 8-bit instance for ops, flags and
// multi-cycle handshakes, and a 16-bit instance for the ROW/COL/INCL field ops.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, c_ain8, c_bin8, c_alu8, c_aout8;
    logic [3:0] op8;
    logic [7:0] a_in8, b_in8;
    wire  [7:0] a_out8;
    wire        flag8, zero8, carry8, busy8, done8;

    logic        rst16, c_ain16, c_bin16, c_alu16, c_aout16;
    logic [3:0]  op16;
    logic [15:0] a_in16, b_in16;
    wire  [15:0] a_out16;
    wire         flag16, zero16, carry16, busy16, done16;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .opcode(op8), .a_in(a_in8), .b_in(b_in8),
        .c_ain(c_ain8), .c_bin(c_bin8), .c_alu(c_alu8), .c_aout(c_aout8),
        .a_out(a_out8), .flag(flag8), .zero(zero8), .carry(carry8),
        .busy(busy8), .done(done8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst16), .opcode(op16), .a_in(a_in16), .b_in(b_in16),
        .c_ain(c_ain16), .c_bin(c_bin16), .c_alu(c_alu16), .c_aout(c_aout16),
        .a_out(a_out16), .flag(flag16), .zero(zero16), .carry(carry16),
        .busy(busy16), .done(done16)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_a;
        logic       exp_c;
        logic       exp_z;
        logic       exp_f;
    } vec_t;

    vec_t vecs [15];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load A and B, issue the op, return in the cycle after the op edge with c_alu dropped.
    task automatic op8_run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        c_ain8 = 1'b1; c_bin8 = 1'b1; a_in8 = a; b_in8 = b; c_alu8 = 1'b0;
        @(negedge clk);
        c_ain8 = 1'b0; c_bin8 = 1'b0; c_alu8 = 1'b1; op8 = op;
        @(negedge clk);
        c_alu8 = 1'b0;
    endtask

    task automatic op16_run(input logic [3:0] op, input logic ld_a, input logic [15:0] a,
                            input logic [15:0] b);
        c_ain16 = ld_a; c_bin16 = 1'b1; a_in16 = a; b_in16 = b; c_alu16 = 1'b0;
        @(negedge clk);
        c_ain16 = 1'b0; c_bin16 = 1'b0; c_alu16 = 1'b1; op16 = op;
        @(negedge clk);
        c_alu16 = 1'b0;
    endtask

    task automatic wait_done8(output int bcnt, output bit ok);
        bcnt = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin
                ok = 1'b1;
                break;
            end
            if (busy8) bcnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bcnt;
        bit ok;
        bit seen;

        vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB,  8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_ADDI, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB,  8'h05, 8'h06, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_AND,  8'hCC, 8'hAA, 8'h88, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_OR,   8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{OP_XOR,  8'h5A, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{OP_F,    8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{OP_F,    8'h3C, 8'h3D, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{OP_INCL, 8'h01, 8'h07, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_ROW,  8'h00, 8'hA5, 8'h0A, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{OP_COL,  8'hFF, 8'hA5, 8'h05, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{OP_SHL,  8'h33, 8'h08, 8'h33, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'd13,   8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};

        rst8 = 1'b1; c_ain8 = 1'b0; c_bin8 = 1'b0; c_alu8 = 1'b0; c_aout8 = 1'b1;
        op8 = 4'd0; a_in8 = '0; b_in8 = '0;
        rst16 = 1'b1; c_ain16 = 1'b0; c_bin16 = 1'b0; c_alu16 = 1'b0; c_aout16 = 1'b1;
        op16 = 4'd0; a_in16 = '0; b_in16 = '0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;
        @(negedge clk);

        check("reset_a",     a_out8, 8'h00);
        check("reset_flags", {flag8, zero8, carry8}, 3'b000);
        check("reset_busy",  busy8, 1'b0);
        check("reset_done",  done8, 1'b0);

        for (int i = 0; i < 15; i++) begin
            op8_run(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_a", i),     a_out8, vecs[i].exp_a);
            check($sformatf("vec%0d_carry", i), carry8, vecs[i].exp_c);
            check($sformatf("vec%0d_zero", i),  zero8,  vecs[i].exp_z);
            check($sformatf("vec%0d_flag", i),  flag8,  vecs[i].exp_f);
            check($sformatf("vec%0d_done", i),  done8,  1'b1);
            check($sformatf("vec%0d_busy", i),  busy8,  1'b0);
        end
        @(negedge clk);
        check("done_one_cycle", done8, 1'b0);

        // MUL without high-half overflow, then with.
        op8_run(OP_MUL, 8'd13, 8'd11);
        wait_done8(bcnt, ok);
        check("mul1_done_seen", ok, 1'b1);
        check("mul1_busy_cycles", bcnt, 8);
        check("mul1_a", a_out8, 8'h8F);
        check("mul1_carry", carry8, 1'b0);
        check("mul1_busy_at_done", busy8, 1'b0);
        @(negedge clk);
        check("mul1_done_drop", done8, 1'b0);

        op8_run(OP_MUL, 8'd20, 8'd20);
        wait_done8(bcnt, ok);
        check("mul2_done_seen", ok, 1'b1);
        check("mul2_busy_cycles", bcnt, 8);
        check("mul2_a", a_out8, 8'h90);
        check("mul2_carry", carry8, 1'b1);
        check("mul2_zero", zero8, 1'b0);

        // SHL by 3 with strobes issued while busy, then back-to-back ADD in the done cycle.
        op8_run(OP_SHL, 8'h01, 8'h03);
        check("shl_busy_start", busy8, 1'b1);
        check("shl_old_a_on_bus", a_out8, 8'h01);
        c_alu8 = 1'b1; op8 = OP_ADD; c_ain8 = 1'b1; a_in8 = 8'hEE; c_bin8 = 1'b1; b_in8 = 8'h77;
        @(negedge clk);
        c_alu8 = 1'b0; c_ain8 = 1'b0; c_bin8 = 1'b0;
        check("shl_a_held", a_out8, 8'h01);
        wait_done8(bcnt, ok);
        check("shl_done_seen", ok, 1'b1);
        check("shl_busy_cycles", bcnt + 1, 3);
        check("shl_a", a_out8, 8'h08);
        check("shl_busy_at_done", busy8, 1'b0);
        c_alu8 = 1'b1; op8 = OP_ADD;
        @(negedge clk);
        c_alu8 = 1'b0;
        check("b2b_add_done", done8, 1'b1);
        check("b2b_add_a", a_out8, 8'h0B);

        op8_run(OP_SHR, 8'h80, 8'h07);
        wait_done8(bcnt, ok);
        check("shr_done_seen", ok, 1'b1);
        check("shr_busy_cycles", bcnt, 7);
        check("shr_a", a_out8, 8'h01);

        // Reset in the fourth busy cycle of a MUL aborts it without a done pulse.
        op8_run(OP_MUL, 8'd13, 8'd11);
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy8, 1'b1);
        #2 rst8 = 1'b1;
        #1;
        check("abort_a", a_out8, 8'h00);
        check("abort_busy", busy8, 1'b0);
        @(negedge clk);
        rst8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | done8 | busy8;
            @(negedge clk);
        end
        check("abort_no_done", seen, 1'b0);
        op8_run(OP_ADD, 8'h02, 8'h03);
        check("post_abort_add_a", a_out8, 8'h05);
        check("post_abort_add_done", done8, 1'b1);

        // 16-bit field ops.
        op16_run(OP_ROW, 1'b1, 16'h0000, 16'hABCD);
        check("w16_row", a_out16, 16'h00AB);
        op16_run(OP_COL, 1'b0, 16'h0000, 16'hABCD);
        check("w16_col", a_out16, 16'h00CD);
        op16_run(OP_INCL, 1'b0, 16'h0000, 16'h000F);
        check("w16_incl", a_out16, 16'h80CD);
        check("w16_incl_done", done16, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
